aes_round_sequencer: RTL and testbench

Round scheduler for the AES core. It steps the round datapath through rounds 0..NR under a valid/ready handshake. For each round it presents the round index, first/last flags and the key-expansion round constant. The constant is generated iteratively in GF(2^8), so no lookup table is needed. The sequencer sits between the top-level command interface and the round/key-expansion datapath, and is the only source of round sequencing in the core.

---
 rtl/aes_pkg.sv | 47 ++++
 rtl/aes_rcon_step.sv | 27 ++
 rtl/aes_round_sequencer.sv | 168 ++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
//   Shared definitions for the AES round sequencer:
//     - state_e       : sequencer FSM states (IDLE, RUN, DONE)
//     - RCON_POLY     : AES reduction polynomial low byte (x^8 = x^4+x^3+x+1)
//     - RCON_INV_POLY : constant folded in when dividing by x in GF(2^8)
//     - xtime         : multiply by x in GF(2^8)
//     - inv_xtime     : divide by x in GF(2^8)
//     - rcon_pow(n)   : x^n in GF(2^8), evaluated at elaboration time
//   Optional feature macro used by the files importing this package:
//     AES_DECRYPT_EN
// -----------------------------------------------------------------------------
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] RCON_POLY     = 8'h1b;
  localparam logic [7:0] RCON_INV_POLY = 8'h8d;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    logic [7:0] s;
    s = {r[6:0], 1'b0};
    return r[7] ? (s ^ RCON_POLY) : s;
  endfunction

  // Inverse of xtime: a set bit0 means the value was reduced, so undo the
  // reduction (0x11b >> 1 = 0x8d) while shifting right.
  function automatic logic [7:0] inv_xtime(input logic [7:0] r);
    logic [7:0] s;
    s = {1'b0, r[7:1]};
    return r[0] ? (s ^ RCON_INV_POLY) : s;
  endfunction

  function automatic logic [7:0] rcon_pow(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < n; i++) begin
      r = xtime(r);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_rcon_step.sv
// -----------------------------------------------------------------------------
// aes_rcon_step
//   Combinational one-step update of the key-expansion round constant.
//   Forward (encrypt order) multiplies by x; backward (decrypt order, only with
//   AES_DECRYPT_EN) divides by x.
// Ports:
//   dir_i   in  1  0 = forward, 1 = backward   (only with AES_DECRYPT_EN)
//   rcon_i  in  8  current round constant
//   rcon_o  out 8  constant for the neighbouring round
// -----------------------------------------------------------------------------
module aes_rcon_step
  import aes_pkg::*;
(
`ifdef AES_DECRYPT_EN
  input  logic       dir_i,
`endif
  input  logic [7:0] rcon_i,
  output logic [7:0] rcon_o
);

`ifdef AES_DECRYPT_EN
  assign rcon_o = dir_i ? inv_xtime(rcon_i) : xtime(rcon_i);
`else
  assign rcon_o = xtime(rcon_i);
`endif

endmodule

// File: rtl/aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer
//   Steps the AES round datapath through rounds 0..NR (or NR..0 when
//   decrypting) under a valid/ready handshake, presenting round index,
//   first/last flags and the round constant for each round.
//   Optional feature macro: AES_DECRYPT_EN (adds i_Decrypt and descending
//   order with inverse constant stepping).
// Parameters:
//   NR             number of rounds (10, 12 or 14)
// Ports:
//   clk            in   1  clock, rising edge
//   rst_n          in   1  asynchronous active-low reset
//   i_Start        in   1  start a block (sampled only in IDLE)
//   i_Abort        in   1  synchronous abort to IDLE, highest priority
//   i_Decrypt      in   1  descending order (only with AES_DECRYPT_EN)
//   i_Round_Ready  in   1  datapath accepts the presented round
//   o_Busy         out  1  high in RUN and DONE
//   o_Round_Valid  out  1  round fields valid
//   o_Round_Idx    out  4  current round index
//   o_Rcon         out  8  round constant (00 for round 0)
//   o_First        out  1  first round of the block
//   o_Last         out  1  final round of the block
//   o_Done         out  1  one-cycle pulse after the last round is accepted
// -----------------------------------------------------------------------------
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_Start,
  input  logic       i_Abort,
`ifdef AES_DECRYPT_EN
  input  logic       i_Decrypt,
`endif
  input  logic       i_Round_Ready,
  output logic       o_Busy,
  output logic       o_Round_Valid,
  output logic [3:0] o_Round_Idx,
  output logic [7:0] o_Rcon,
  output logic       o_First,
  output logic       o_Last,
  output logic       o_Done
);

  localparam logic [3:0] NR_IDX = 4'(NR);

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] rcon_q, rcon_d;
  logic       dec_q, dec_d;

  logic       start_dec;
  logic [3:0] start_idx;
  logic [7:0] start_rcon;
  logic [7:0] step_rcon;
  logic [7:0] next_rcon;
  logic       run;
  logic       accept;
  logic       first_round;
  logic       last_round;

  // Start values for a new block depend on the direction sampled with i_Start.
`ifdef AES_DECRYPT_EN
  localparam logic [7:0] DEC_START_RCON = rcon_pow(NR - 1);

  assign start_dec  = i_Decrypt;
  assign start_idx  = i_Decrypt ? NR_IDX : 4'd0;
  assign start_rcon = i_Decrypt ? DEC_START_RCON : 8'h00;
`else
  assign start_dec  = 1'b0;
  assign start_idx  = 4'd0;
  assign start_rcon = 8'h00;
`endif

  aes_rcon_step u_rcon_step (
`ifdef AES_DECRYPT_EN
    .dir_i  (dec_q),
`endif
    .rcon_i (rcon_q),
    .rcon_o (step_rcon)
  );

  assign run         = (state_q == RUN);
  assign accept      = run & i_Round_Ready;
  assign first_round = dec_q ? (idx_q == NR_IDX) : (idx_q == 4'd0);
  assign last_round  = dec_q ? (idx_q == 4'd0)   : (idx_q == NR_IDX);

  // Round 0 carries no constant, so the chain is seeded with 01 when leaving
  // round 0 and cleared to 00 when arriving at round 0 in descending order.
  always_comb begin
    next_rcon = step_rcon;
    if (!dec_q && idx_q == 4'd0) begin
      next_rcon = 8'h01;
    end else if (dec_q && idx_q == 4'd1) begin
      next_rcon = 8'h00;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    dec_d   = dec_q;

    case (state_q)
      IDLE: begin
        if (i_Start) begin
          state_d = RUN;
          dec_d   = start_dec;
          idx_d   = start_idx;
          rcon_d  = start_rcon;
        end
      end
      RUN: begin
        if (accept) begin
          if (last_round) begin
            state_d = DONE;
            idx_d   = 4'd0;
            rcon_d  = 8'h00;
          end else begin
            idx_d   = dec_q ? (idx_q - 4'd1) : (idx_q + 4'd1);
            rcon_d  = next_rcon;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        dec_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (i_Abort) begin
      state_d = IDLE;
      idx_d   = 4'd0;
      rcon_d  = 8'h00;
      dec_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      rcon_q  <= 8'h00;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      dec_q   <= dec_d;
    end
  end

  // Outputs decode directly from registered state so reset clears them at once.
  assign o_Busy        = (state_q != IDLE);
  assign o_Round_Valid = run;
  assign o_Round_Idx   = run ? idx_q : 4'd0;
  assign o_Rcon        = (run && idx_q != 4'd0) ? rcon_q : 8'h00;
  assign o_First       = run & first_round;
  assign o_Last        = run & last_round;
  assign o_Done        = (state_q == DONE);

endmodule

// File: tb/tb_aes_round_sequencer.sv
module tb_aes_round_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       ready;
`ifdef AES_DECRYPT_EN
  logic       decrypt;
`endif
  logic       busy;
  logic       valid;
  logic [3:0] idx;
  logic [7:0] rcon;
  logic       first;
  logic       last;
  logic       done;

  int checks;
  int fails;

  logic [7:0] enc_rcon [0:10];

  aes_round_sequencer #(.NR(10)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_Start       (start),
    .i_Abort       (abort),
`ifdef AES_DECRYPT_EN
    .i_Decrypt     (decrypt),
`endif
    .i_Round_Ready (ready),
    .o_Busy        (busy),
    .o_Round_Valid (valid),
    .o_Round_Idx   (idx),
    .o_Rcon        (rcon),
    .o_First       (first),
    .o_Last        (last),
    .o_Done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    ready = 1'b0;
`ifdef AES_DECRYPT_EN
    decrypt = 1'b0;
`endif
    #3;
    checks++;
    if ({busy, valid, idx, rcon, first, last, done} !== 17'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0", {busy, valid, idx, rcon, first, last, done});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b valid=%b expected 0 0", busy, valid);
    end
  endtask

  task automatic test_encrypt();
    int dones;
    dones = 0;
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      checks++;
      if (valid !== 1'b1 || idx !== 4'(i) || rcon !== enc_rcon[i] ||
          first !== (i == 0) || last !== (i == 10)) begin
        fails++;
        $display("FAIL enc_round%0d: valid=%b idx=%0d rcon=%h first=%b last=%b expected 1 %0d %h %b %b",
                 i, valid, idx, rcon, first, last, i, enc_rcon[i], (i == 0), (i == 10));
      end
      if (done === 1'b1) dones++;
      tick();
    end
    // t+12
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || valid !== 1'b0) begin
      fails++;
      $display("FAIL enc_done: done=%b busy=%b valid=%b expected 1 1 0", done, busy, valid);
    end
    if (done === 1'b1) dones++;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL enc_idle_after: done=%b busy=%b expected 0 0", done, busy);
    end
    checks++;
    if (dones != 1) begin
      fails++;
      $display("FAIL enc_done_count: got %0d expected 1", dones);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    for (int i = 0; i <= 10; i++) begin
      if (i == 4) begin
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (valid !== 1'b1 || idx !== 4'd4 || rcon !== 8'h08 || done !== 1'b0) begin
            fails++;
            $display("FAIL bp_stall%0d: valid=%b idx=%0d rcon=%h done=%b expected 1 4 08 0",
                     k, valid, idx, rcon, done);
          end
          tick();
          cyc++;
        end
        ready = 1'b1;
      end
      checks++;
      if (idx !== 4'(i) || rcon !== enc_rcon[i] || done !== 1'b0) begin
        fails++;
        $display("FAIL bp_round%0d: idx=%0d rcon=%h done=%b expected %0d %h 0",
                 i, idx, rcon, done, i, enc_rcon[i]);
      end
      tick();
      cyc++;
    end
    checks++;
    if (done !== 1'b1 || cyc != 15) begin
      fails++;
      $display("FAIL bp_done: done=%b at cycle %0d expected 1 at 15", done, cyc);
    end
    tick();
  endtask

  task automatic test_abort();
    int dones;
    dones = 0;
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    checks++;
    if (idx !== 4'd6 || rcon !== 8'h20) begin
      fails++;
      $display("FAIL abort_pre: idx=%0d rcon=%h expected 6 20", idx, rcon);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, valid, idx, rcon, first, last, done} !== 17'd0) begin
      fails++;
      $display("FAIL abort_idle: got %h expected 0", {busy, valid, idx, rcon, first, last, done});
    end
    for (int k = 0; k < 8; k++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones != 0) begin
      fails++;
      $display("FAIL abort_no_done: got %0d pulses expected 0", dones);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (valid !== 1'b1 || idx !== 4'd0 || rcon !== 8'h00 || first !== 1'b1) begin
      fails++;
      $display("FAIL abort_restart: valid=%b idx=%0d rcon=%h first=%b expected 1 0 00 1",
               valid, idx, rcon, first);
    end
    tick();
    checks++;
    if (idx !== 4'd1 || rcon !== 8'h01) begin
      fails++;
      $display("FAIL abort_restart1: idx=%0d rcon=%h expected 1 01", idx, rcon);
    end
    repeat (11) tick();
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_restart_end: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_start_ignored();
    int rounds;
    int firsts;
    rounds = 0;
    firsts = 0;
    ready = 1'b1;
    start = 1'b1;
    tick();
    // keep start high through RUN and the DONE cycle
    for (int k = 0; k < 11; k++) begin
      if (valid === 1'b1) rounds++;
      if (first === 1'b1) firsts++;
      tick();
    end
    checks++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      fails++;
      $display("FAIL ign_done: done=%b valid=%b expected 1 0", done, valid);
    end
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || rounds != 11 || firsts != 1) begin
      fails++;
      $display("FAIL ign_count: busy=%b rounds=%0d firsts=%0d expected 0 11 1", busy, rounds, firsts);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      fails++;
      $display("FAIL ign_stays_idle: busy=%b valid=%b expected 0 0", busy, valid);
    end
  endtask

`ifdef AES_DECRYPT_EN
  task automatic test_decrypt();
    ready = 1'b1;
    decrypt = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    decrypt = 1'b0;
    for (int i = 10; i >= 0; i--) begin
      checks++;
      if (valid !== 1'b1 || idx !== 4'(i) || rcon !== enc_rcon[i] ||
          first !== (i == 10) || last !== (i == 0)) begin
        fails++;
        $display("FAIL dec_round%0d: valid=%b idx=%0d rcon=%h first=%b last=%b expected 1 %0d %h %b %b",
                 i, valid, idx, rcon, first, last, i, enc_rcon[i], (i == 10), (i == 0));
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL dec_done: done=%b expected 1", done);
    end
    tick();
  endtask
`endif

  task automatic test_reset_midblock();
    int dones;
    dones = 0;
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    checks++;
    if (idx !== 4'd5 || rcon !== 8'h10) begin
      fails++;
      $display("FAIL rst_pre: idx=%0d rcon=%h expected 5 10", idx, rcon);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, valid, idx, rcon, first, last, done} !== 17'd0) begin
      fails++;
      $display("FAIL rst_async: got %h expected 0", {busy, valid, idx, rcon, first, last, done});
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      if (done === 1'b1 || busy === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones != 0) begin
      fails++;
      $display("FAIL rst_no_done: busy/done seen %0d times expected 0", dones);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    enc_rcon[0]  = 8'h00; enc_rcon[1]  = 8'h01; enc_rcon[2]  = 8'h02;
    enc_rcon[3]  = 8'h04; enc_rcon[4]  = 8'h08; enc_rcon[5]  = 8'h10;
    enc_rcon[6]  = 8'h20; enc_rcon[7]  = 8'h40; enc_rcon[8]  = 8'h80;
    enc_rcon[9]  = 8'h1b; enc_rcon[10] = 8'h36;
    test_reset();
    test_encrypt();
    test_backpressure();
    test_abort();
    test_start_ignored();
`ifdef AES_DECRYPT_EN
    test_decrypt();
`endif
    test_reset_midblock();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
